clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
- Measures a slow, asynchronous periodic signal, such as a divided clock or a board-level strobe, in cycles of the fast system clock.
- Reports the period and high time of each completed cycle, and flags a stalled input.
- It is the receiving end for the team's divided-clock outputs: debug or readback logic uses it to confirm a slow clock is present and at the intended rate.

Parameters:
- CNT_W, 32, width of the cycle counters and of the period/high_time outputs.
- TIMEOUT, 200000000, clk cycles without a rising edge before the input is declared stalled.
  - Legal range: 2 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  measurement enable, synchronous to clk.
- sig_in  in  1  asynchronous signal under measurement.
- period  out  CNT_W  clk cycles between the last two rising edges of sig_in.
- high_time  out  CNT_W  clk cycles sig_in was high within that period.
- valid  out  1  one-cycle strobe; period and high_time were updated this cycle.
- stalled  out  1  level; no rising edge seen for TIMEOUT cycles.
- meas_cnt  out  16  number of completed measurements; wraps at 65535 -> 0.

Behaviour:
- Reset (async, rst=1) clears all state:
  - period, high_time, valid, stalled, meas_cnt, cnt, high_cap = 0.
  - Both synchroniser FFs and the edge register = 0.
  - FSM = IDLE.
- Synchroniser: two FFs, sig_in -> s1 -> s2, then s_d <= s2.
  - rise = s2 & ~s_d; fall = ~s2 & s_d.
  - Both are single-cycle strobes and are mutually exclusive.
  - Edge detection lags sig_in by 3 clk cycles; the lag is equal for both edges, so measurements are unaffected.
- FSM states: IDLE, MEASURE.
- IDLE:
  - cnt held at 0; valid = 0.
  - On rise with en=1: go to MEASURE, cnt <= 1, stalled <= 0.
  - This first rise only arms the meter; it produces no valid.
- MEASURE, each cycle with en=1:
  - cnt <= cnt+1, saturating at TIMEOUT.
  - On fall: high_cap <= cnt.
  - On rise, in the same cycle:
    - period <= cnt, high_time <= high_cap.
    - valid <= 1 (visible the next cycle, together with the new values).
    - meas_cnt <= meas_cnt+1; cnt <= 1.
  - Result: a stable square wave of N clk cycles with H high cycles yields period = N and high_time = H exactly.
  - If cnt == TIMEOUT and there is no rise this cycle: stalled <= 1, go to IDLE. No valid is produced; period, high_time and meas_cnt keep their last values.
- Simultaneous rise and timeout (cnt == TIMEOUT in the same cycle): the rise wins. The measurement completes with period = TIMEOUT and stalled stays 0.
- en = 0 in any state:
  - Go to IDLE next cycle; cnt <= 0; valid <= 0.
  - Outputs hold their values, and stalled holds.
  - The synchroniser keeps running, so re-enable does not produce a stale edge.
  - After re-enable, the first rise arms only.
- valid is never high for two consecutive cycles, because the minimum detectable period is 2 clk cycles.
- sig_in high at reset release is reported as a rise ~3 cycles later. That rise arms only.
- Reset mid-measurement: everything is cleared as above, and no valid is issued for the partial cycle.
- All arithmetic is unsigned.
  - cnt never exceeds TIMEOUT, so no CNT_W overflow is possible.
  - meas_cnt wraps modulo 2^16.

Test Plan (TIMEOUT=1000, CNT_W=32 unless noted):
- Square wave, period 8 clk, high 3 clk, started 10 cycles after reset:
  - The first rise gives no valid.
  - Every subsequent rise gives a valid strobe one cycle wide, with period=8 and high_time=3.
  - meas_cnt increments by 1 per valid; stalled=0.
- Period changes from 8 to 20 (high 10) mid-stream: the first valid after the change shows period=20, high_time=10. No intermediate garbage value appears.
- sig_in held low after 5 good periods:
  - Exactly 1000 cycles after the last counted rise, stalled=1.
  - No further valid; period stays 8.
  - Restarting the wave gives stalled=0 on the first rise, and valid on the second rise.
- Rise arriving exactly when cnt==1000 (period 1000): valid with period=1000 and stalled stays 0. With period 1001: stalled=1 and no valid.
- rst pulsed for 2 cycles mid-period: all outputs read 0 during and after reset, and no valid occurs until two rises have completed.
- en dropped for 50 cycles during an active wave: no valid while en=0; outputs hold. After en=1, the first rise arms and the second gives a correct period.
- Force meas_cnt near wrap: 65536 measurements -> meas_cnt reads 0 and still increments on the next valid.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow asynchronous
// signal in clk cycles, and flags an input that has stopped toggling.
module clk_period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 200000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stalled,
  output logic [15:0]      meas_cnt
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s_d;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cap;

  // Synchroniser runs regardless of en so re-enable sees no stale edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= sig_in;
      s2  <= s1;
      s_d <= s2;
    end
  end

  assign rise = s2 & ~s_d;
  assign fall = ~s2 & s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      high_cap  <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b0;
      meas_cnt  <= '0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state   <= MEASURE;
              cnt     <= CNT_W'(1);
              stalled <= 1'b0;
            end
          end
          MEASURE: begin
            if (fall) high_cap <= cnt;
            // A rise coinciding with the timeout still completes a period.
            if (rise) begin
              period    <= cnt;
              high_time <= high_cap;
              valid     <= 1'b1;
              meas_cnt  <= meas_cnt + 16'd1;
              cnt       <= CNT_W'(1);
            end else if (cnt == TMO) begin
              stalled <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: random and directed waves on sig_in, checked each
// cycle against a timestamp-based model of the meter.
module tb_clk_period_meter;

  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        stalled;
  logic [15:0] meas_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W  (32),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .stalled  (stalled),
    .meas_cnt (meas_cnt)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sig_in seen through a 3-sample delay, edges timestamped.
  bit          samp[$];
  bit          m_rise;
  bit          m_fall;
  bit          armed;
  int unsigned k = 0;
  int unsigned t_rise;
  int unsigned t_fall;
  logic [31:0] m_period;
  logic [31:0] m_high;
  logic        m_valid;
  logic        m_stalled;
  logic [15:0] m_meas;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samp      = '{1'b0, 1'b0, 1'b0};
      armed     = 1'b0;
      m_period  = '0;
      m_high    = '0;
      m_valid   = 1'b0;
      m_stalled = 1'b0;
      m_meas    = '0;
    end else begin
      m_rise  = samp[1] & ~samp[0];
      m_fall  = ~samp[1] & samp[0];
      m_valid = 1'b0;
      if (!en) begin
        armed = 1'b0;
      end else if (!armed) begin
        if (m_rise) begin
          armed     = 1'b1;
          t_rise    = k;
          m_stalled = 1'b0;
        end
      end else begin
        if (m_fall) t_fall = k;
        if (m_rise) begin
          m_period = 32'(k - t_rise);
          m_high   = 32'(t_fall - t_rise);
          m_valid  = 1'b1;
          m_meas   = m_meas + 16'd1;
          t_rise   = k;
        end else if (k - t_rise == TMO) begin
          m_stalled = 1'b1;
          armed     = 1'b0;
        end
      end
      samp.push_back(sig_in);
      void'(samp.pop_front());
    end
    k++;
  end

  int nvalid = 0;
  int ncyc = 0;
  int t_last_valid = 0;
  int t_stall = 0;
  logic prev_stalled = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    chk("period", period, m_period);
    chk("high_time", high_time, m_high);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("stalled", 32'(stalled), 32'(m_stalled));
    chk("meas_cnt", 32'(meas_cnt), 32'(m_meas));
    if (valid === 1'b1) begin
      nvalid++;
      t_last_valid = ncyc;
    end
    if (stalled === 1'b1 && prev_stalled === 1'b0) t_stall = ncyc;
    prev_stalled = stalled;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wave(int n, int h, int reps);
    for (int r = 0; r < reps; r++) begin
      sig_in = 1'b1;
      repeat (h) step();
      sig_in = 1'b0;
      repeat (n - h) step();
    end
  endtask

  int v0;

  initial begin
    repeat (3) step();
    chk("rst_period", period, 32'd0);
    chk("rst_meas", 32'(meas_cnt), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (10) step();

    v0 = nvalid;
    wave(8, 3, 6);
    chk("sq_period", period, 32'd8);
    chk("sq_high", high_time, 32'd3);
    chk("sq_nvalid", 32'(nvalid - v0), 32'd5);
    chk("sq_meas", 32'(meas_cnt), 32'd5);
    chk("sq_model", m_period, 32'd8);

    wave(20, 10, 4);
    chk("chg_period", period, 32'd20);
    chk("chg_high", high_time, 32'd10);

    wave(8, 3, 5);
    v0 = nvalid;
    repeat (1100) step();
    chk("stall_flag", 32'(stalled), 32'd1);
    chk("stall_period", period, 32'd8);
    chk("stall_nvalid", 32'(nvalid - v0), 32'd0);
    chk("stall_delay", 32'(t_stall - t_last_valid), 32'd1000);

    v0 = nvalid;
    wave(8, 3, 2);
    chk("restart_stalled", 32'(stalled), 32'd0);
    chk("restart_nvalid", 32'(nvalid - v0), 32'd1);

    wave(1000, 500, 3);
    chk("p1000_period", period, 32'd1000);
    chk("p1000_stalled", 32'(stalled), 32'd0);
    v0 = nvalid;
    wave(1001, 500, 3);
    repeat (20) step();
    chk("p1001_stalled", 32'(stalled), 32'd1);
    chk("p1001_nvalid", 32'(nvalid - v0), 32'd1);
    chk("p1001_period", period, 32'd1000);

    wave(8, 3, 3);
    sig_in = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    chk("rstmid_period", period, 32'd0);
    chk("rstmid_stalled", 32'(stalled), 32'd0);
    sig_in = 1'b0;
    rst    = 1'b0;
    step();
    chk("rstmid_meas", 32'(meas_cnt), 32'd0);
    v0 = nvalid;
    wave(8, 3, 3);
    chk("rstmid_nvalid", 32'(nvalid - v0), 32'd2);
    chk("rstmid_meas2", 32'(meas_cnt), 32'd2);

    fork
      wave(10, 4, 12);
      begin
        repeat (35) step();
        en = 1'b0;
        step();
        v0 = nvalid;
        repeat (49) step();
        chk("en_off_nvalid", 32'(nvalid - v0), 32'd0);
        en = 1'b1;
      end
    join
    chk("en_period", period, 32'd10);
    chk("en_high", high_time, 32'd4);

    for (int i = 0; i < 15; i++) begin
      int n;
      int h;
      n  = int'($urandom_range(2, 40));
      h  = int'($urandom_range(1, n - 1));
      en = ($urandom_range(0, 7) != 0);
      wave(n, h, int'($urandom_range(2, 5)));
      repeat ($urandom_range(0, 30)) step();
    end

    en     = 1'b0;
    sig_in = 1'b0;
    repeat (5) step();
    force dut.meas_cnt = 16'hFFFE;
    m_meas = 16'hFFFE;
    step();
    release dut.meas_cnt;
    step();
    en = 1'b1;
    wave(4, 2, 4);
    repeat (10) step();
    chk("wrap_meas", 32'(meas_cnt), 32'd1);

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
